wb_dest_tracker: RTL

- Producer side of the ID-stage hazard interface: the control unit reads the in-flight destination-register information and buffer-ready flag, and this block generates them.
- Tracks each issued instruction's register-write intent and destination through the ID/EX, EX/MEM and MEM/SAD slots.
- Injects bubbles on ID stall.
- Counts retired SAD buffer loads to produce all_buf_flags for the all-buffer (ABUF) instruction.

---
 rtl/wb_dest_tracker_pkg.sv | 17 +
 rtl/wb_dest_tracker_sat_load_counter.sv | 29 ++
 rtl/wb_dest_tracker.sv | 103 ++++++++++
 3 files changed

// File: rtl/wb_dest_tracker_pkg.sv
// Shared types for the writeback destination tracker: slot entry layout and constants.
package wb_dest_tracker_pkg;

    localparam int REGW    = 5;
    localparam int ENTRY_W = 8;
    localparam logic [REGW-1:0] JAL_REG = 5'd31;

    typedef struct packed {
        logic            rw;
        logic [REGW-1:0] wr;
        logic            ka;
        logic            kb;
    } slot_t;

    localparam slot_t BUBBLE = '{rw: 1'b0, wr: '0, ka: 1'b0, kb: 1'b0};

endpackage

// File: rtl/wb_dest_tracker_sat_load_counter.sv
// Saturating load counter; a clear coinciding with an increment restarts the count at 1.
module sat_load_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = inc_i ? W'(1) : '0;
        else if (inc_i && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/wb_dest_tracker.sv
// In-flight destination tracker for ID hazard detection plus SAD buffer-full flag.
// Optional WB_TRACKER_PERF_EN adds a saturating stall-bubble counter output.
module wb_dest_tracker
    import wb_dest_tracker_pkg::*;
#(
    parameter int BUF_A_LOADS = 4,
    parameter int BUF_B_LOADS = 4,
    parameter int CNT_W       = 4
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            Hold,
    input  logic            ID_stall,
    input  logic            ID_RegWrite,
    input  logic            ID_R,
    input  logic            ID_JALControl,
    input  logic [REGW-1:0] rt,
    input  logic [REGW-1:0] rd,
    input  logic            ID_load_buff_a,
    input  logic            ID_load_buff_b,
    input  logic            ID_buff,
    output logic            ID_EX_RegWrite,
    output logic [REGW-1:0] EX_WriteRegister,
    output logic            EX_MEM_RegWrite,
    output logic [REGW-1:0] EX_MEM_WriteRegister,
    output logic            MEM_SAD_RegWrite,
    output logic [REGW-1:0] MEM_SAD_WriteRegister,
    output logic            all_buf_flags
`ifdef WB_TRACKER_PERF_EN
   ,output logic [15:0]     bubble_count
`endif
);

    slot_t           id_ex_q, ex_mem_q, mem_sad_q;
    slot_t           new_d;
    logic [REGW-1:0] dest;
    logic            adv, clr;
    logic [CNT_W-1:0] cnt_a, cnt_b;

    assign adv = ~Hold;
    assign clr = adv & ID_buff & ~ID_stall;

    always_comb begin
        dest = ID_JALControl ? JAL_REG : (ID_R ? rd : rt);
        new_d    = BUBBLE;
        new_d.rw = ID_RegWrite & (dest != '0);
        new_d.wr = dest;
        new_d.ka = ID_load_buff_a;
        new_d.kb = ID_load_buff_b;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            id_ex_q   <= BUBBLE;
            ex_mem_q  <= BUBBLE;
            mem_sad_q <= BUBBLE;
        end else if (adv) begin
            mem_sad_q <= ex_mem_q;
            ex_mem_q  <= id_ex_q;
            id_ex_q   <= ID_stall ? BUBBLE : new_d;
        end
    end

    // Retirement is whatever sits in MEM/SAD at an advancing edge.
    sat_load_counter #(.W(CNT_W)) u_cnt_a (
        .clk   (Clk),
        .rst_n (Rst_n),
        .clr_i (clr),
        .inc_i (adv & mem_sad_q.ka),
        .cnt_o (cnt_a)
    );

    sat_load_counter #(.W(CNT_W)) u_cnt_b (
        .clk   (Clk),
        .rst_n (Rst_n),
        .clr_i (clr),
        .inc_i (adv & mem_sad_q.kb),
        .cnt_o (cnt_b)
    );

    assign all_buf_flags = (int'(cnt_a) >= BUF_A_LOADS) && (int'(cnt_b) >= BUF_B_LOADS);

    assign ID_EX_RegWrite        = id_ex_q.rw;
    assign EX_WriteRegister      = id_ex_q.wr;
    assign EX_MEM_RegWrite       = ex_mem_q.rw;
    assign EX_MEM_WriteRegister  = ex_mem_q.wr;
    assign MEM_SAD_RegWrite      = mem_sad_q.rw;
    assign MEM_SAD_WriteRegister = mem_sad_q.wr;

`ifdef WB_TRACKER_PERF_EN
    logic [15:0] bub_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            bub_q <= '0;
        else if (adv && ID_stall && (bub_q != 16'hFFFF))
            bub_q <= bub_q + 16'd1;
    end

    assign bubble_count = bub_q;
`endif

endmodule
